pipeline_control: RTL and testbench
===================================

// Module: pipeline_control
// PURPOSE
//  Central sequencer for the 5-stage pipeline (fetch/decode/exec/mem/wb). Drives en/zero
//  (stall/flush) for every pipeline latch and selects the next PC source. Detects load-use
//  hazards, memory and fetch waits, branch mispredicts (resolved in exec) and decode jumps.
//  Runs the halt drain FSM.
// PARAMETERS
//  CNT_W        32  width of performance counters (PIPE_PERF_CNT_EN only)
// PORTS
//  CLK            in   1  system clock, rising edge
//  nRST           in   1  asynchronous active-low reset
//  ihit           in   1  instruction fetch complete this cycle
//  dhit           in   1  data access complete this cycle
//  ex_dmem_req    in   1  mem-stage latch holds dmemREN|dmemWEN
//  ex_dmemREN     in   1  exec-stage latch holds a load
//  ex_wsel        in   5  exec-stage destination register
//  id_rs, id_rt   in   5  decode-stage source registers (rs_alu_in/rt_alu_in)
//  id_jump        in   1  decode is a J/JAL/JR (jump_instr)
//  id_halt        in   1  decode holds HALT
//  ex_branch      in   1  exec-stage latch holds BEQ/BNE
//  ex_branch_if_zero in 1 exec branch is BEQ
//  ex_alu_zero    in   1  exec ALU zero flag
//  ex_branch_taken in  1  predicted-taken bit carried with the exec branch
//  wb_halt        in   1  HALT has reached writeback
//  pc_en          out  1  PC register update enable
//  pc_src         out  2  pc_src_t: PC_NPC, PC_BRANCH, PC_BRANCH_NT, PC_JUMP
//  fd_en, fd_zero out  1  fetch/decode latch enable, bubble-insert (zero valid only with en)
//  de_en, de_zero out  1  decode/exec latch
//  em_en, em_zero out  1  exec/mem latch
//  mw_en, mw_zero out  1  mem/wb latch
//  halt           out  1  registered, sticky processor-halted flag
// BEHAVIOUR
//  Control outputs are combinational from state and inputs (0-cycle); only FSM/halt/counters register.
//  Reset: state=RUN, halt=0; all en outputs evaluate to 0 while nRST low, pc_src=PC_NPC.
//  Hazard terms (priority high->low, first match applies):
//   mem_stall  = ex_dmem_req & !dhit: pc/fd/de/em en=0; mw_en=1, mw_zero=1. Mispredict held off.
//   mispredict = ex_branch & ((ex_alu_zero==ex_branch_if_zero) != ex_branch_taken):
//     pc_en=1, pc_src=PC_BRANCH (actual taken) or PC_BRANCH_NT (fall-through);
//     fd/de zero=1, en=1. Overrides load-use and jump.
//   load_use   = ex_dmemREN & ex_wsel!=0 & (ex_wsel==id_rs | ex_wsel==id_rt):
//     pc_en=0, fd_en=0; de_en=1, de_zero=1; em/mw advance.
//   id_jump: pc_en=1, pc_src=PC_JUMP, fd_zero=1 (only if no higher term).
//   fetch_stall = !ihit: pc_en=0, fd_en=1, fd_zero=1; downstream advances normally.
//   none: all en=1, zero=0, pc_src=PC_NPC.
//  FSM (pctl_state_t):
//   RUN: id_halt & !mem_stall & !mispredict -> DRAIN.
//   DRAIN: pc_en=0, fd_zero=1; hazard terms above still apply downstream.
//     mispredict -> RUN (HALT was wrong-path, flushed).
//     wb_halt -> HALTED.
//   HALTED: all en=0, halt=1; exit only via nRST.
//   Reset mid-DRAIN returns to RUN with halt=0.
//  Simultaneous: wb_halt & mispredict in DRAIN -> HALTED (older instruction wins).
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs cyc_cnt, stall_cnt, flush_cnt (CNT_W each).
//   Reset to 0; increment on every cycle / any stall term / each mispredict|jump.
//   Saturate at all-ones; frozen while HALTED.
//  Undefined: ports and counters absent; no other behaviour changes.
// STRUCTURE
//  cpu_types_pkg gains pctl_state_t {RUN, DRAIN, HALTED} and pc_src_t.
//  Sub-module sat_counter #(W) (en, clr, q) instanced 3x under PIPE_PERF_CNT_EN.
// TESTING
//  Load-use: ex_dmemREN=1, ex_wsel=5, id_rs=5 -> pc_en=0, fd_en=0, de_zero=1. ex_wsel=0 -> no stall.
//  Mispredict: ex_branch=1, BEQ, zero=1, taken=0 -> pc_src=PC_BRANCH, fd_zero=de_zero=1.
//   Same with taken=1 -> no flush.
//  Mem wait: ex_dmem_req=1, dhit=0 for 3 cycles with a mispredict pending -> only mw bubbles;
//   flush fires the cycle dhit=1.
//  Halt: id_halt=1 -> DRAIN, pc_en=0; wb_halt 3 cycles later -> halt=1, all en=0 until nRST.
//  Wrong-path halt: DRAIN then mispredict -> RUN, halt stays 0, fetch resumes.
//  PIPE_PERF_CNT_EN: force counter near all-ones, 4 stalls -> stall_cnt saturates; reset clears all.

Source files
------------

// File: rtl/pipeline_control_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_control_pkg
//   Shared types for the 5-stage pipeline sequencer:
//     pctl_state_t : halt drain FSM state (RUN, DRAIN, HALTED)
//     pc_src_t     : next-PC source select
//     hazard_t     : the single hazard term that wins the priority chain
//     pctl_ctrl_t  : bundle of every latch en/zero plus PC controls
// ----------------------------------------------------------------------------
package pipeline_control_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pctl_state_t;

  typedef enum logic [1:0] {
    PC_NPC       = 2'd0,
    PC_BRANCH    = 2'd1,
    PC_BRANCH_NT = 2'd2,
    PC_JUMP      = 2'd3
  } pc_src_t;

  typedef enum logic [2:0] {
    HZ_NONE        = 3'd0,
    HZ_MEM_STALL   = 3'd1,
    HZ_MISPREDICT  = 3'd2,
    HZ_LOAD_USE    = 3'd3,
    HZ_JUMP        = 3'd4,
    HZ_FETCH_STALL = 3'd5
  } hazard_t;

  typedef struct packed {
    logic    pc_en;
    pc_src_t pc_src;
    logic    fd_en;
    logic    fd_zero;
    logic    de_en;
    logic    de_zero;
    logic    em_en;
    logic    em_zero;
    logic    mw_en;
    logic    mw_zero;
  } pctl_ctrl_t;

  // Free-flowing pipeline: every latch loads, nothing squashed, sequential PC.
  localparam pctl_ctrl_t CTRL_FLOW = '{
    pc_en: 1'b1, pc_src: PC_NPC,
    fd_en: 1'b1, fd_zero: 1'b0,
    de_en: 1'b1, de_zero: 1'b0,
    em_en: 1'b1, em_zero: 1'b0,
    mw_en: 1'b1, mw_zero: 1'b0
  };

  // Everything frozen (reset and halted).
  localparam pctl_ctrl_t CTRL_HOLD = '{
    pc_en: 1'b0, pc_src: PC_NPC,
    fd_en: 1'b0, fd_zero: 1'b0,
    de_en: 1'b0, de_zero: 1'b0,
    em_en: 1'b0, em_zero: 1'b0,
    mw_en: 1'b0, mw_zero: 1'b0
  };

  function automatic logic is_stall(hazard_t h);
    return (h == HZ_MEM_STALL) || (h == HZ_LOAD_USE) || (h == HZ_FETCH_STALL);
  endfunction

  function automatic logic is_flush(hazard_t h);
    return (h == HZ_MISPREDICT) || (h == HZ_JUMP);
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// ----------------------------------------------------------------------------
// pipeline_control_if
//   Hazard status from the datapath and latch/PC controls back to it.
//   master : datapath side (drives status, receives controls)
//   slave  : pipeline_control (receives status, drives controls)
// ----------------------------------------------------------------------------
interface pipeline_control_if;
  import pipeline_control_pkg::*;

  // status from the datapath
  logic       ihit;
  logic       dhit;
  logic       ex_dmem_req;
  logic       ex_dmemREN;
  logic [4:0] ex_wsel;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_jump;
  logic       id_halt;
  logic       ex_branch;
  logic       ex_branch_if_zero;
  logic       ex_alu_zero;
  logic       ex_branch_taken;
  logic       wb_halt;

  // controls to the datapath
  logic       pc_en;
  pc_src_t    pc_src;
  logic       fd_en;
  logic       fd_zero;
  logic       de_en;
  logic       de_zero;
  logic       em_en;
  logic       em_zero;
  logic       mw_en;
  logic       mw_zero;
  logic       halt;

  modport master (
    output ihit, dhit, ex_dmem_req, ex_dmemREN, ex_wsel, id_rs, id_rt,
           id_jump, id_halt, ex_branch, ex_branch_if_zero, ex_alu_zero,
           ex_branch_taken, wb_halt,
    input  pc_en, pc_src, fd_en, fd_zero, de_en, de_zero, em_en, em_zero,
           mw_en, mw_zero, halt
  );

  modport slave (
    input  ihit, dhit, ex_dmem_req, ex_dmemREN, ex_wsel, id_rs, id_rt,
           id_jump, id_halt, ex_branch, ex_branch_if_zero, ex_alu_zero,
           ex_branch_taken, wb_halt,
    output pc_en, pc_src, fd_en, fd_zero, de_en, de_zero, em_en, em_zero,
           mw_en, mw_zero, halt
  );

endinterface

// File: rtl/pipeline_control_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for pipeline performance statistics.
//   Ports: clk, rst_n (async active-low), en (count), clr (sync clear),
//          q (count value, sticks at all-ones).
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipeline_control.sv
// ----------------------------------------------------------------------------
// pipeline_control
//   Central sequencer for the fetch/decode/exec/mem/wb pipeline. Resolves
//   hazards (memory wait, branch mispredict, load-use, decode jump, fetch
//   wait) into latch enable/zero controls and the next-PC source, and runs
//   the halt drain FSM (RUN -> DRAIN -> HALTED).
//
//   Ports:
//     CLK       rising-edge clock
//     nRST      asynchronous active-low reset
//     bus       pipeline_control_if.slave: hazard status in, controls out
//     cyc_cnt, stall_cnt, flush_cnt (CNT_W each, only with PIPE_PERF_CNT_EN)
//
//   Build option: PIPE_PERF_CNT_EN adds saturating performance counters.
//   Control outputs are combinational; only the FSM, halt flag and counters
//   are registered.
// ----------------------------------------------------------------------------
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               nRST,
  pipeline_control_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  if (CNT_W < 2) begin : g_cnt_w_check
    $error("pipeline_control: CNT_W must be at least 2");
  end

  pctl_state_t state_q, state_d;
  logic        halt_q, halt_d;
  hazard_t     hz;
  pctl_ctrl_t  ctrl;

  logic mem_stall;
  logic br_actual_taken;
  logic mispredict;
  logic load_use;

  assign mem_stall       = bus.ex_dmem_req & ~bus.dhit;
  // BEQ is taken on zero, BNE on non-zero.
  assign br_actual_taken = (bus.ex_alu_zero == bus.ex_branch_if_zero);
  assign mispredict      = bus.ex_branch & (br_actual_taken != bus.ex_branch_taken);
  // r0 is hardwired, so a load into it never creates a dependency.
  assign load_use        = bus.ex_dmemREN & (bus.ex_wsel != 5'd0) &
                           ((bus.ex_wsel == bus.id_rs) | (bus.ex_wsel == bus.id_rt));

  // Priority chain: exactly one hazard term is applied per cycle.
  always_comb begin
    if (mem_stall) begin
      hz = HZ_MEM_STALL;
    end else if (mispredict) begin
      hz = HZ_MISPREDICT;
    end else if (load_use) begin
      hz = HZ_LOAD_USE;
    end else if (bus.id_jump) begin
      hz = HZ_JUMP;
    end else if (!bus.ihit) begin
      hz = HZ_FETCH_STALL;
    end else begin
      hz = HZ_NONE;
    end
  end

  always_comb begin
    ctrl    = CTRL_FLOW;
    state_d = state_q;
    halt_d  = halt_q;

    case (hz)
      HZ_MEM_STALL: begin
        // Everything upstream of mem freezes; wb receives a bubble.
        ctrl.pc_en   = 1'b0;
        ctrl.fd_en   = 1'b0;
        ctrl.de_en   = 1'b0;
        ctrl.em_en   = 1'b0;
        ctrl.mw_zero = 1'b1;
      end
      HZ_MISPREDICT: begin
        ctrl.pc_src  = br_actual_taken ? PC_BRANCH : PC_BRANCH_NT;
        ctrl.fd_zero = 1'b1;
        ctrl.de_zero = 1'b1;
      end
      HZ_LOAD_USE: begin
        ctrl.pc_en   = 1'b0;
        ctrl.fd_en   = 1'b0;
        ctrl.de_zero = 1'b1;
      end
      HZ_JUMP: begin
        ctrl.pc_src  = PC_JUMP;
        ctrl.fd_zero = 1'b1;
      end
      HZ_FETCH_STALL: begin
        ctrl.pc_en   = 1'b0;
        ctrl.fd_zero = 1'b1;
      end
      default: ;
    endcase

    case (state_q)
      RUN: begin
        // A HALT next to a mispredict is on the wrong path and gets flushed.
        if (bus.id_halt && (hz != HZ_MEM_STALL) && (hz != HZ_MISPREDICT)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Fetch is shut off; only a mispredict redirect (wrong-path HALT)
        // may restart it, and a HALT retiring in wb takes precedence.
        ctrl.pc_en   = (hz == HZ_MISPREDICT) && !bus.wb_halt;
        ctrl.fd_zero = ctrl.fd_en;
        if (bus.wb_halt) begin
          state_d = HALTED;
          halt_d  = 1'b1;
        end else if (hz == HZ_MISPREDICT) begin
          state_d = RUN;
        end
      end
      HALTED: begin
        ctrl = CTRL_HOLD;
      end
      default: begin
        ctrl    = CTRL_HOLD;
        state_d = RUN;
      end
    endcase

    if (!nRST) begin
      ctrl = CTRL_HOLD;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign bus.pc_en   = ctrl.pc_en;
  assign bus.pc_src  = ctrl.pc_src;
  assign bus.fd_en   = ctrl.fd_en;
  assign bus.fd_zero = ctrl.fd_zero;
  assign bus.de_en   = ctrl.de_en;
  assign bus.de_zero = ctrl.de_zero;
  assign bus.em_en   = ctrl.em_en;
  assign bus.em_zero = ctrl.em_zero;
  assign bus.mw_en   = ctrl.mw_en;
  assign bus.mw_zero = ctrl.mw_zero;
  assign bus.halt    = halt_q;

`ifdef PIPE_PERF_CNT_EN
  logic cnt_live;
  assign cnt_live = (state_q != HALTED);

  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (cnt_live),
    .clr   (1'b0),
    .q     (cyc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (cnt_live && is_stall(hz)),
    .clr   (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .en    (cnt_live && is_flush(hz)),
    .clr   (1'b0),
    .q     (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// ----------------------------------------------------------------------------
// tb_pipeline_control
//   Directed scenarios followed by randomized hazard traffic, every cycle
//   compared against a rule-level reference model of the sequencer.
// ----------------------------------------------------------------------------
module tb_pipeline_control;
  import pipeline_control_pkg::*;

  localparam int M_RUN    = 0;
  localparam int M_DRAIN  = 1;
  localparam int M_HALTED = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  pipeline_control_if bus ();

  int n_checks = 0;
  int n_fail   = 0;
  int mode     = M_RUN;

`ifdef PIPE_PERF_CNT_EN
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic [CW-1:0] cyc_cnt, stall_cnt, flush_cnt;
  int m_cyc = 0, m_stall = 0, m_flush = 0;

  pipeline_control #(.CNT_W(CW)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .bus       (bus),
    .cyc_cnt   (cyc_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  pipeline_control dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Which rule applies this cycle, evaluated straight from the rule list.
  function automatic void get_terms(output logic ms, output logic mp, output logic lu,
                                    output logic jp, output logic fs, output logic tk);
    ms = bus.ex_dmem_req && !bus.dhit;
    tk = (bus.ex_alu_zero == bus.ex_branch_if_zero);
    mp = !ms && bus.ex_branch && (tk != bus.ex_branch_taken);
    lu = !ms && !mp && bus.ex_dmemREN && (bus.ex_wsel != 5'd0) &&
         ((bus.ex_wsel == bus.id_rs) || (bus.ex_wsel == bus.id_rt));
    jp = !ms && !mp && !lu && bus.id_jump;
    fs = !ms && !mp && !lu && !jp && !bus.ihit;
  endfunction

  // Expected {pc_en, pc_src, fd_en, fd_zero, de_en, de_zero, em_en, em_zero, mw_en, mw_zero}
  function automatic logic [10:0] model_ctrl(input int m);
    logic ms, mp, lu, jp, fs, tk;
    logic pe, fe, fz, dz;
    logic [1:0] src;
    if (!nRST || m == M_HALTED) return 11'd0;
    get_terms(ms, mp, lu, jp, fs, tk);
    pe  = !(ms || lu || fs);
    fe  = !(ms || lu);
    fz  = mp || jp || fs;
    dz  = mp || lu;
    src = mp ? (tk ? 2'd1 : 2'd2) : (jp ? 2'd3 : 2'd0);
    if (m == M_DRAIN) begin
      pe = mp && !bus.wb_halt;
      fz = fe;
    end
    return {pe, src, fe, fz, !ms, dz, !ms, 1'b0, 1'b1, ms};
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {bus.pc_en, bus.pc_src, bus.fd_en, bus.fd_zero, bus.de_en, bus.de_zero,
            bus.em_en, bus.em_zero, bus.mw_en, bus.mw_zero};
  endfunction

  task automatic set_idle();
    bus.ihit = 1'b1; bus.dhit = 1'b1; bus.ex_dmem_req = 1'b0; bus.ex_dmemREN = 1'b0;
    bus.ex_wsel = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_jump = 1'b0;
    bus.id_halt = 1'b0; bus.ex_branch = 1'b0; bus.ex_branch_if_zero = 1'b0;
    bus.ex_alu_zero = 1'b0; bus.ex_branch_taken = 1'b0; bus.wb_halt = 1'b0;
  endtask

  // Let inputs settle, then compare all outputs with the model.
  task automatic settle(input string tag);
    #1;
    check_eq({tag, ".ctrl"}, 32'(dut_ctrl()), 32'(model_ctrl(mode)));
    check_eq({tag, ".halt"}, 32'(bus.halt), 32'(mode == M_HALTED));
`ifdef PIPE_PERF_CNT_EN
    check_eq({tag, ".cyc_cnt"}, 32'(cyc_cnt), 32'(m_cyc));
    check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
    check_eq({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
`endif
    $display("%0t %s mode=%0d ctrl=%b halt=%b", $time, tag, mode, dut_ctrl(), bus.halt);
  endtask

  // Clock edge: advance the model with the inputs seen this cycle.
  task automatic advance();
    logic ms, mp, lu, jp, fs, tk;
    int nm;
    get_terms(ms, mp, lu, jp, fs, tk);
    nm = mode;
    if (mode == M_RUN && bus.id_halt && !ms && !mp) nm = M_DRAIN;
    else if (mode == M_DRAIN && bus.wb_halt) nm = M_HALTED;
    else if (mode == M_DRAIN && mp) nm = M_RUN;
    @(posedge CLK);
`ifdef PIPE_PERF_CNT_EN
    if (mode != M_HALTED) begin
      if (m_cyc < CMAX) m_cyc++;
      if ((ms || lu || fs) && m_stall < CMAX) m_stall++;
      if ((mp || jp) && m_flush < CMAX) m_flush++;
    end
`endif
    mode = nm;
    #1;
  endtask

  task automatic step(input string tag);
    settle(tag);
    advance();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    check_eq("rst.ctrl", 32'(dut_ctrl()), 32'd0);
    check_eq("rst.halt", 32'(bus.halt), 32'd0);
    mode = M_RUN;
`ifdef PIPE_PERF_CNT_EN
    m_cyc = 0; m_stall = 0; m_flush = 0;
    check_eq("rst.cyc_cnt", 32'(cyc_cnt), 32'd0);
`endif
    $display("%0t reset", $time);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    set_idle();
    #2;
    do_reset();
    step("idle");

    // Load-use on rs, then the same load into r0 (no hazard).
    bus.ex_dmemREN = 1'b1; bus.ex_wsel = 5'd5; bus.id_rs = 5'd5;
    settle("lu");
    check_eq("lu.pc_en", 32'(bus.pc_en), 32'd0);
    check_eq("lu.fd_en", 32'(bus.fd_en), 32'd0);
    check_eq("lu.de_zero", 32'(bus.de_zero), 32'd1);
    advance();
    bus.ex_wsel = 5'd0;
    settle("lu_r0");
    check_eq("lu_r0.pc_en", 32'(bus.pc_en), 32'd1);
    advance();
    set_idle();

    // BEQ taken, predicted not-taken -> redirect; predicted taken -> no flush.
    bus.ex_branch = 1'b1; bus.ex_branch_if_zero = 1'b1; bus.ex_alu_zero = 1'b1;
    settle("mp");
    check_eq("mp.pc_src", 32'(bus.pc_src), 32'(PC_BRANCH));
    check_eq("mp.fd_zero", 32'(bus.fd_zero), 32'd1);
    check_eq("mp.de_zero", 32'(bus.de_zero), 32'd1);
    advance();
    bus.ex_branch_taken = 1'b1;
    settle("mp_ok");
    check_eq("mp_ok.fd_zero", 32'(bus.fd_zero), 32'd0);
    advance();

    // Memory wait holds off a pending mispredict.
    bus.ex_branch_taken = 1'b0; bus.ex_dmem_req = 1'b1; bus.dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle("memw");
      check_eq("memw.mw_zero", 32'(bus.mw_zero), 32'd1);
      check_eq("memw.fd_zero", 32'(bus.fd_zero), 32'd0);
      check_eq("memw.pc_en", 32'(bus.pc_en), 32'd0);
      advance();
    end
    bus.dhit = 1'b1;
    settle("memw_hit");
    check_eq("memw_hit.fd_zero", 32'(bus.fd_zero), 32'd1);
    check_eq("memw_hit.pc_src", 32'(bus.pc_src), 32'(PC_BRANCH));
    advance();
    set_idle();

    // Halt drain to HALTED, held until reset.
    bus.id_halt = 1'b1;
    step("halt_id");
    bus.id_halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle("drain");
      check_eq("drain.pc_en", 32'(bus.pc_en), 32'd0);
      advance();
    end
    bus.wb_halt = 1'b1;
    step("wb_halt");
    bus.wb_halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle("halted");
      check_eq("halted.halt", 32'(bus.halt), 32'd1);
      check_eq("halted.fd_en", 32'(bus.fd_en), 32'd0);
      advance();
    end
    do_reset();
    settle("post_rst");
    check_eq("post_rst.halt", 32'(bus.halt), 32'd0);
    advance();

    // Wrong-path HALT: mispredict in DRAIN returns to RUN.
    bus.id_halt = 1'b1;
    step("wp_halt");
    bus.id_halt = 1'b0;
    step("wp_drain");
    bus.ex_branch = 1'b1; bus.ex_branch_if_zero = 1'b1; bus.ex_alu_zero = 1'b0;
    bus.ex_branch_taken = 1'b1;
    settle("wp_mp");
    check_eq("wp_mp.pc_en", 32'(bus.pc_en), 32'd1);
    check_eq("wp_mp.pc_src", 32'(bus.pc_src), 32'(PC_BRANCH_NT));
    advance();
    set_idle();
    settle("wp_run");
    check_eq("wp_run.pc_en", 32'(bus.pc_en), 32'd1);
    check_eq("wp_run.halt", 32'(bus.halt), 32'd0);
    advance();

    // wb_halt and mispredict together in DRAIN: the older HALT wins.
    bus.id_halt = 1'b1;
    step("both_halt");
    bus.id_halt = 1'b0; bus.wb_halt = 1'b1;
    bus.ex_branch = 1'b1; bus.ex_branch_if_zero = 1'b1; bus.ex_alu_zero = 1'b1;
    step("both");
    set_idle();
    settle("both_after");
    check_eq("both_after.halt", 32'(bus.halt), 32'd1);
    advance();
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bus.ihit              = ($urandom_range(0, 9) < 8);
      bus.dhit              = ($urandom_range(0, 9) < 7);
      bus.ex_dmem_req       = ($urandom_range(0, 9) < 3);
      bus.ex_dmemREN        = ($urandom_range(0, 9) < 3);
      bus.ex_wsel           = 5'($urandom_range(0, 3));
      bus.id_rs             = 5'($urandom_range(0, 3));
      bus.id_rt             = 5'($urandom_range(0, 3));
      bus.id_jump           = ($urandom_range(0, 9) == 0);
      bus.id_halt           = ($urandom_range(0, 24) == 0);
      bus.ex_branch         = ($urandom_range(0, 9) < 3);
      bus.ex_branch_if_zero = 1'($urandom_range(0, 1));
      bus.ex_alu_zero       = 1'($urandom_range(0, 1));
      bus.ex_branch_taken   = 1'($urandom_range(0, 1));
      bus.wb_halt           = ($urandom_range(0, 9) == 0);
      step("rnd");
      if ((mode == M_HALTED && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
